// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect, and the
// decode-side handshake. The master modport is the fetch unit's view.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        instr_misalign;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, instr_misalign,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, instr_misalign,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch with credit-limited requests, a small PC/word FIFO and redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets become a single trap entry.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, DRAIN = 2'b10} state_t;

    state_t          state_r, state_nx_s;
    logic [31:0]     fetch_pc_r, fetch_pc_nx_s, resp_pc_r, resp_pc_nx_s;
    logic [CW-1:0]   inflight_r, inflight_nx_s, discard_r, discard_nx_s, count_r;
    logic [AW-1:0]   rd_ptr_r, wr_ptr_r, wr_idx_s;
    logic [31:0]     data_mem_r [DEPTH];
    logic [31:0]     pc_mem_r   [DEPTH];
    logic [DEPTH-1:0] mis_mem_r;
    logic            halt_r, halt_nx_s;
    logic [31:0]     target_pc_s, push_data_s, push_pc_s;
    logic            trap_s, push_s, pop_s, flush_s, push_mis_s;
    logic            active_s, credit_s, req_s, accept_s, rsp_s, head_valid_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_pc_s = bus.redirect_pc;
    assign trap_s      = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
    assign target_pc_s = bus.redirect_pc & 32'hFFFF_FFFC;
    assign trap_s      = 1'b0;
`endif

    // Words already in the FIFO still hold a credit, so a full FIFO can never overflow.
    assign active_s     = (state_r != BOOT);
    assign credit_s     = ({1'b0, inflight_r} + {1'b0, count_r}) < DEPTH_W;
    assign req_s        = active_s && credit_s && !bus.redirect_valid && !halt_r;
    assign accept_s     = req_s && bus.imem_ready;
    assign rsp_s        = active_s && bus.imem_rvalid;
    assign head_valid_s = (count_r != CW'(1'b0));
    assign wr_idx_s     = flush_s ? AW'(1'b0) : wr_ptr_r;

    assign bus.imem_req       = req_s;
    assign bus.imem_addr      = fetch_pc_r;
    assign bus.instr_valid    = head_valid_s;
    assign bus.instr          = head_valid_s ? data_mem_r[rd_ptr_r] : NOP;
    assign bus.instr_pc       = head_valid_s ? pc_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign bus.instr_misalign = head_valid_s && mis_mem_r[rd_ptr_r];

    // Datapath next state; a redirect overrides push, pop and PC advance in its cycle.
    always_comb begin
        flush_s       = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        push_data_s   = bus.imem_rdata;
        push_pc_s     = resp_pc_r;
        push_mis_s    = 1'b0;
        fetch_pc_nx_s = fetch_pc_r;
        resp_pc_nx_s  = resp_pc_r;
        discard_nx_s  = discard_r;
        halt_nx_s     = halt_r;
        inflight_nx_s = inflight_r + CW'(accept_s) - CW'(rsp_s);
        if (bus.redirect_valid) begin
            flush_s       = 1'b1;
            fetch_pc_nx_s = target_pc_s;
            resp_pc_nx_s  = target_pc_s;
            discard_nx_s  = inflight_nx_s;
            halt_nx_s     = trap_s;
            if (trap_s) begin
                push_s      = 1'b1;
                push_data_s = NOP;
                push_pc_s   = target_pc_s;
                push_mis_s  = 1'b1;
            end else begin
                push_s = 1'b0;
            end
        end else begin
            pop_s = head_valid_s && bus.instr_ready;
            if (accept_s) begin
                fetch_pc_nx_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_nx_s = fetch_pc_r;
            end
            if (rsp_s && (discard_r != CW'(1'b0))) begin
                discard_nx_s = discard_r - CW'(1'b1);
            end else if (rsp_s) begin
                push_s       = 1'b1;
                resp_pc_nx_s = resp_pc_r + 32'd4;
            end else begin
                discard_nx_s = discard_r;
            end
        end
    end

    // FSM next state: DRAIN lasts exactly as long as wrong-path responses are outstanding.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            BOOT:    state_nx_s = RUN;
            RUN: begin
                if (bus.redirect_valid && (discard_nx_s != CW'(1'b0))) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DRAIN: begin
                if (discard_nx_s == CW'(1'b0)) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            default: state_nx_s = BOOT;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= BOOT;
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            inflight_r <= CW'(1'b0);
            discard_r  <= CW'(1'b0);
            halt_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            fetch_pc_r <= fetch_pc_nx_s;
            resp_pc_r  <= resp_pc_nx_s;
            inflight_r <= inflight_nx_s;
            discard_r  <= discard_nx_s;
            halt_r     <= halt_nx_s;
        end
    end

    // FIFO storage and pointers; a flush restarts at slot 0 so a trap entry lands at the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
            mis_mem_r <= {DEPTH{1'b0}};
            rd_ptr_r  <= AW'(1'b0);
            wr_ptr_r  <= AW'(1'b0);
            count_r   <= CW'(1'b0);
        end else begin
            if (push_s) begin
                data_mem_r[wr_idx_s] <= push_data_s;
                pc_mem_r[wr_idx_s]   <= push_pc_s;
                mis_mem_r[wr_idx_s]  <= push_mis_s;
            end
            if (flush_s) begin
                rd_ptr_r <= AW'(1'b0);
                wr_ptr_r <= AW'(push_s);
                count_r  <= CW'(push_s);
            end else begin
                rd_ptr_r <= rd_ptr_r + AW'(pop_s);
                wr_ptr_r <= wr_ptr_r + AW'(push_s);
                count_r  <= count_r + CW'(push_s) - CW'(pop_s);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with per-request latency,
// a scoreboard of expected fetch addresses / decode PCs, a redirect vector table and corner sequences.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus_if ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] rpc; logic [31:0] exp_pc; bit trap; } vec_t;

    mreq_t       mq [$];
    vec_t        vecs [6];
    int          tnow, lat, n_chk, n_fail;
    logic        req_q, rdy_q, ivalid_q, irdy_q, mis_q;
    logic [31:0] addr_q, instr_q, ipc_q, exp_pc, exp_addr;
    bit          halted;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a ^ 32'hC0DE_0000) + 32'h0000_1000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, then advance the memory model.
    task automatic cyc();
        @(negedge clk);
        req_q    = bus_if.imem_req;
        rdy_q    = bus_if.imem_ready;
        addr_q   = bus_if.imem_addr;
        ivalid_q = bus_if.instr_valid;
        irdy_q   = bus_if.instr_ready;
        instr_q  = bus_if.instr;
        ipc_q    = bus_if.instr_pc;
        mis_q    = bus_if.instr_misalign;
        @(posedge clk);
        #1;
        tnow++;
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = 32'h0000_0000;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (req_q && rdy_q) mq.push_back('{addr_q, tnow - 1 + lat});
            if (mq.size() > 0 && mq[0].due <= tnow) begin
                bus_if.imem_rvalid = 1'b1;
                bus_if.imem_rdata  = data_of(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    endtask

    // Run n cycles checking every accepted address and every consumed word against the expectations.
    task automatic run_sb(input int n, input int min_pops);
        int pops = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            if (halted) chk("trap_noreq", {31'b0, req_q}, 32'h0);
            else if (req_q && rdy_q) begin
                chk("imem_addr", addr_q, exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
            if (ivalid_q && irdy_q) begin
                pops++;
                if (halted) begin
                    chk("trap_pops", pops, 32'd1);
                    chk("trap_pc", ipc_q, exp_pc);
                    chk("trap_instr", instr_q, NOP);
                    chk("trap_mis", {31'b0, mis_q}, 32'h1);
                end else begin
                    chk("instr_pc", ipc_q, exp_pc);
                    chk("instr", instr_q, data_of(exp_pc));
                    chk("misalign", {31'b0, mis_q}, 32'h0);
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        n_chk++;
        if (pops < min_pops) begin
            n_fail++;
            $display("FAIL pop_count: got %0d expected at least %0d", pops, min_pops);
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = pc;
        cyc();
        chk("redir_noreq", {31'b0, req_q}, 32'h0);
        bus_if.redirect_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0100, 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[1] = '{32'h0000_0102, 32'h0000_0102, 1'b1};
        vecs[3] = '{32'h0000_0203, 32'h0000_0203, 1'b1};
`else
        vecs[1] = '{32'h0000_0102, 32'h0000_0100, 1'b0};
        vecs[3] = '{32'h0000_0203, 32'h0000_0200, 1'b0};
`endif
        vecs[2] = '{32'h2000_0004, 32'h2000_0004, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[5] = '{32'h0000_0040, 32'h0000_0040, 1'b0};

        n_chk = 0; n_fail = 0; tnow = 0; lat = 1; halted = 1'b0;
        bus_if.imem_ready     = 1'b1;
        bus_if.imem_rvalid    = 1'b0;
        bus_if.imem_rdata     = 32'h0000_0000;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0000_0000;
        bus_if.instr_ready    = 1'b1;

        // Reset state, then BOOT cycle without request, then streaming from RESET_PC.
        repeat (2) cyc();
        chk("rst_req", {31'b0, req_q}, 32'h0);
        chk("rst_addr", addr_q, 32'h0000_0000);
        chk("rst_valid", {31'b0, ivalid_q}, 32'h0);
        chk("rst_instr", instr_q, NOP);
        chk("rst_pc", ipc_q, 32'h0000_0000);
        chk("rst_mis", {31'b0, mis_q}, 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("boot_noreq", {31'b0, req_q}, 32'h0);
        exp_pc = 32'h0; exp_addr = 32'h0;
        run_sb(20, 8);

        // Decoder stall: requests stop once credit is used, nothing lost or duplicated.
        bus_if.instr_ready = 1'b0;
        run_sb(10, 0);
        chk("stall_req", {31'b0, req_q}, 32'h0);
        chk("stall_valid", {31'b0, ivalid_q}, 32'h1);
        chk("stall_head", ipc_q, exp_pc);
        bus_if.instr_ready = 1'b1;
        run_sb(20, 8);

        // Redirect target table (alignment, wrap through 0xFFFF_FFFC, optional trap).
        for (int i = 0; i < 6; i++) begin
            redirect(vecs[i].rpc);
            exp_pc = vecs[i].exp_pc; exp_addr = vecs[i].exp_pc; halted = vecs[i].trap;
            run_sb(8, vecs[i].trap ? 1 : 3);
        end
        halted = 1'b0;

        // Two wrong-path responses in flight when redirecting to 0x100.
        bus_if.instr_ready = 1'b0;
        repeat (6) cyc();
        lat = 3;
        redirect(32'h0000_0080);
        cyc();
        chk("drain_req0", {31'b0, req_q}, 32'h1);
        chk("drain_addr0", addr_q, 32'h0000_0080);
        cyc();
        chk("drain_req1", {31'b0, req_q}, 32'h1);
        chk("drain_addr1", addr_q, 32'h0000_0084);
        lat = 1;
        redirect(32'h0000_0100);
        cyc();
        chk("drain_addr", addr_q, 32'h0000_0100);
        chk("drain_noreq", {31'b0, req_q}, 32'h0);
        chk("drain_empty", {31'b0, ivalid_q}, 32'h0);
        bus_if.instr_ready = 1'b1;
        exp_pc = 32'h0000_0100; exp_addr = 32'h0000_0100;
        run_sb(10, 3);

        // Redirect in the same cycle as a response and a pop.
        bus_if.instr_ready = 1'b0;
        repeat (6) cyc();
        redirect(32'h0000_0200);
        cyc();
        chk("coin_addr0", addr_q, 32'h0000_0200);
        cyc();
        chk("coin_addr1", addr_q, 32'h0000_0204);
        bus_if.instr_ready    = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_0300;
        cyc();
        bus_if.redirect_valid = 1'b0;
        chk("coin_head_valid", {31'b0, ivalid_q}, 32'h1);
        chk("coin_head_pc", ipc_q, 32'h0000_0200);
        cyc();
        chk("coin_flushed", {31'b0, ivalid_q}, 32'h0);
        chk("coin_instr", instr_q, NOP);
        chk("coin_pc", ipc_q, 32'h0000_0000);
        chk("coin_req", {31'b0, req_q}, 32'h1);
        chk("coin_addr", addr_q, 32'h0000_0300);
        exp_pc = 32'h0000_0300; exp_addr = 32'h0000_0304;
        run_sb(8, 3);

        // Reset in mid-stream restarts from RESET_PC.
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_req", {31'b0, req_q}, 32'h0);
        chk("mid_rst_valid", {31'b0, ivalid_q}, 32'h0);
        chk("mid_rst_addr", addr_q, 32'h0000_0000);
        rst_n = 1'b1;
        cyc();
        chk("mid_boot_noreq", {31'b0, req_q}, 32'h0);
        exp_pc = 32'h0; exp_addr = 32'h0;
        run_sb(6, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
